// File: rtl/game_sequencer.sv
// Turn sequencer for a code-breaking game: commits guesses, waits for peg
// feedback with a timeout, and decides win/loss after each turn.
module game_sequencer #(
    parameter int MAX_TURNS  = 8,
    parameter int FB_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_submit,
    input  logic       btn_mode,
    input  logic       fb_valid,
    input  logic [2:0] exact_count,
    output logic       mode,
    output logic       store_pulse,
    output logic       fb_req,
    output logic [3:0] turn_count,
    output logic       game_won,
    output logic       game_lost,
    output logic       fb_timeout,
    output logic [2:0] state_dbg
);

    // state   | meaning
    // GUESS   | idle, player composing a guess
    // STORE   | one-cycle strobe committing the guess to history
    // WAIT_FB | requesting feedback, timeout counter running
    // CHECK   | evaluate captured exact count
    // HISTORY | browsing previous guesses
    // WON     | terminal, game won (mode toggles for review)
    // LOST    | terminal, out of turns (mode toggles for review)
    localparam logic [2:0] GUESS   = 3'd0;
    localparam logic [2:0] STORE   = 3'd1;
    localparam logic [2:0] WAIT_FB = 3'd2;
    localparam logic [2:0] CHECK   = 3'd3;
    localparam logic [2:0] HISTORY = 3'd4;
    localparam logic [2:0] WON     = 3'd5;
    localparam logic [2:0] LOST    = 3'd6;

    localparam logic [3:0] MAX_TC  = 4'(MAX_TURNS);
    // Timeout fires on the cycle the counter would reach FB_TIMEOUT.
    localparam logic [7:0] FB_LAST = 8'(FB_TIMEOUT - 1);

    logic [2:0] state_q, state_d;
    logic       mode_q, mode_d;
    logic [3:0] turn_q, turn_d;
    logic       won_q, won_d;
    logic       lost_q, lost_d;
    logic       to_q, to_d;
    logic [7:0] wait_q, wait_d;
    logic [2:0] exact_q, exact_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= GUESS;
            mode_q  <= 1'b0;
            turn_q  <= 4'd0;
            won_q   <= 1'b0;
            lost_q  <= 1'b0;
            to_q    <= 1'b0;
            wait_q  <= 8'd0;
            exact_q <= 3'd0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            turn_q  <= turn_d;
            won_q   <= won_d;
            lost_q  <= lost_d;
            to_q    <= to_d;
            wait_q  <= wait_d;
            exact_q <= exact_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            GUESS: begin
                if (btn_submit)
                    state_d = STORE;
                else if (btn_mode && turn_q != 4'd0)
                    state_d = HISTORY;
            end
            STORE:   state_d = WAIT_FB;
            WAIT_FB: begin
                if (fb_valid || wait_q == FB_LAST)
                    state_d = CHECK;
            end
            CHECK: begin
                if (exact_q == 3'd4)
                    state_d = WON;
                else if (turn_q == MAX_TC)
                    state_d = LOST;
                else
                    state_d = GUESS;
            end
            HISTORY: begin
                if (btn_mode)
                    state_d = GUESS;
            end
            WON:     state_d = WON;
            LOST:    state_d = LOST;
            default: state_d = GUESS;
        endcase
    end

    always_comb begin
        turn_d  = turn_q;
        won_d   = won_q;
        lost_d  = lost_q;
        to_d    = to_q;
        wait_d  = wait_q;
        exact_d = exact_q;

        case (state_d)
            HISTORY:   mode_d = 1'b1;
            WON, LOST: mode_d = (state_q == state_d) ? (mode_q ^ btn_mode) : 1'b0;
            default:   mode_d = 1'b0;
        endcase

        if (state_q == STORE) begin
            wait_d = 8'd0;
            if (turn_q != MAX_TC)
                turn_d = turn_q + 4'd1;
        end

        if (state_q == WAIT_FB) begin
            wait_d = wait_q + 8'd1;
            if (fb_valid) begin
                exact_d = exact_count;
            end else if (wait_q == FB_LAST) begin
                exact_d = 3'd0;
                to_d    = 1'b1;
            end
        end

        if (state_d == WON)
            won_d = 1'b1;
        if (state_d == LOST)
            lost_d = 1'b1;
    end

    always_comb begin
        store_pulse = (state_q == STORE);
        fb_req      = (state_q == WAIT_FB);
        state_dbg   = state_q;
    end

    assign mode       = mode_q;
    assign turn_count = turn_q;
    assign game_won   = won_q;
    assign game_lost  = lost_q;
    assign fb_timeout = to_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: stimulus pushes expected output
// snapshots, a monitor pops one on every state change or explicit probe.
module tb_game_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_submit = 1'b0;
    logic       btn_mode = 1'b0;
    logic       fb_valid = 1'b0;
    logic [2:0] exact_count = 3'd0;
    logic       mode, store_pulse, fb_req, game_won, game_lost, fb_timeout;
    logic [3:0] turn_count;
    logic [2:0] state_dbg;

    logic        probe = 1'b0;
    logic [12:0] sb[$];
    int          n_cmp = 0;
    int          n_mis = 0;

    game_sequencer #(.MAX_TURNS(8), .FB_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .btn_submit(btn_submit), .btn_mode(btn_mode),
        .fb_valid(fb_valid), .exact_count(exact_count), .mode(mode),
        .store_pulse(store_pulse), .fb_req(fb_req), .turn_count(turn_count),
        .game_won(game_won), .game_lost(game_lost), .fb_timeout(fb_timeout),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // snapshot = {state, mode, turn, won, lost, timeout, store_pulse, fb_req}
    function automatic logic [12:0] mk(input logic [2:0] st, input logic md,
                                       input logic [3:0] tc, input logic w,
                                       input logic l, input logic t);
        return {st, md, tc, w, l, t, st == 3'd1, st == 3'd2};
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [12:0] e);
        sb.push_back(e);
    endtask

    task automatic probe_chk(input logic [12:0] e);
        sb.push_back(e);
        probe = 1'b1;
        cyc(1);
        probe = 1'b0;
    endtask

    task automatic press_submit();
        btn_submit = 1'b1;
        cyc(1);
        btn_submit = 1'b0;
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        cyc(1);
        btn_mode = 1'b0;
    endtask

    initial begin : monitor
        logic [2:0]  prev;
        logic [12:0] cur, e;
        prev = 3'd0;
        forever begin
            @(negedge clk);
            cur = {state_dbg, mode, turn_count, game_won, game_lost, fb_timeout,
                   store_pulse, fb_req};
            if (cur[12:10] !== prev || probe) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_mis++;
                    $display("FAIL unexpected_event t=%0t got=%b expected=<none>", $time, cur);
                end else begin
                    e = sb.pop_front();
                    if (cur !== e) begin
                        n_mis++;
                        $display("FAIL snapshot t=%0t got=%b expected=%b", $time, cur, e);
                    end
                end
            end
            prev = cur[12:10];
        end
    end

    logic [2:0] ex_tab [8];
    int         req_cnt;

    initial begin
        ex_tab = '{3'd2, 3'd2, 3'd5, 3'd2, 3'd7, 3'd2, 3'd2, 3'd2};

        cyc(3);
        reset = 1'b0;
        probe_chk(mk(3'd0, 0, 4'd0, 0, 0, 0));

        // mode ignored with no turns played
        press_mode();
        cyc(2);
        probe_chk(mk(3'd0, 0, 4'd0, 0, 0, 0));

        // submit+mode collision, then feedback timeout
        push(mk(3'd1, 0, 4'd0, 0, 0, 0));
        push(mk(3'd2, 0, 4'd1, 0, 0, 0));
        push(mk(3'd3, 0, 4'd1, 0, 0, 1));
        push(mk(3'd0, 0, 4'd1, 0, 0, 1));
        btn_submit = 1'b1;
        btn_mode   = 1'b1;
        cyc(1);
        btn_submit = 1'b0;
        btn_mode   = 1'b0;
        req_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (fb_req) req_cnt++;
        end
        n_cmp++;
        if (req_cnt != 4) begin
            n_mis++;
            $display("FAIL fb_req_cycles got=%0d expected=4", req_cnt);
        end

        // fb_valid outside WAIT_FB ignored
        fb_valid = 1'b1;
        exact_count = 3'd4;
        cyc(2);
        fb_valid = 1'b0;
        probe_chk(mk(3'd0, 0, 4'd1, 0, 0, 1));

        // history view, submit ignored there
        push(mk(3'd4, 1, 4'd1, 0, 0, 1));
        press_mode();
        cyc(2);
        press_submit();
        cyc(2);
        probe_chk(mk(3'd4, 1, 4'd1, 0, 0, 1));
        push(mk(3'd0, 0, 4'd1, 0, 0, 1));
        press_mode();
        cyc(2);

        // reset while waiting for feedback
        push(mk(3'd1, 0, 4'd1, 0, 0, 1));
        push(mk(3'd2, 0, 4'd2, 0, 0, 1));
        push(mk(3'd0, 0, 4'd0, 0, 0, 0));
        press_submit();
        cyc(1);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(2);

        // win path, feedback in third wait cycle
        push(mk(3'd1, 0, 4'd0, 0, 0, 0));
        push(mk(3'd2, 0, 4'd1, 0, 0, 0));
        push(mk(3'd3, 0, 4'd1, 0, 0, 0));
        push(mk(3'd5, 0, 4'd1, 1, 0, 0));
        press_submit();
        cyc(3);
        fb_valid = 1'b1;
        exact_count = 3'd4;
        cyc(1);
        fb_valid = 1'b0;
        exact_count = 3'd0;
        cyc(3);
        press_submit();
        cyc(2);
        probe_chk(mk(3'd5, 0, 4'd1, 1, 0, 0));
        press_mode();
        probe_chk(mk(3'd5, 1, 4'd1, 1, 0, 0));
        press_mode();
        probe_chk(mk(3'd5, 0, 4'd1, 1, 0, 0));

        // loss path over eight turns
        push(mk(3'd0, 0, 4'd0, 0, 0, 0));
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(1);
        for (int i = 1; i <= 8; i++) begin
            push(mk(3'd1, 0, 4'(i - 1), 0, 0, 0));
            push(mk(3'd2, 0, 4'(i), 0, 0, 0));
            push(mk(3'd3, 0, 4'(i), 0, 0, 0));
            if (i < 8) push(mk(3'd0, 0, 4'(i), 0, 0, 0));
            else       push(mk(3'd6, 0, 4'd8, 0, 1, 0));
            press_submit();
            cyc(1);
            fb_valid = 1'b1;
            exact_count = ex_tab[i - 1];
            cyc(1);
            fb_valid = 1'b0;
            cyc(3);
        end
        press_submit();
        cyc(3);
        probe_chk(mk(3'd6, 0, 4'd8, 0, 1, 0));

        cyc(5);
        while (sb.size() > 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL pending_event got=<none> expected=%b", sb.pop_front());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
